// File: rtl/if_id_inst_queue_pkg.sv
// Shared types for the IF->ID fetch queue: entry layout, widths and the NOP word.
package if_id_inst_queue_pkg;

  localparam int PC_W          = 32;
  localparam int INST_W        = 32;
  localparam int DEPTH_DEFAULT = 4;

  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] instr;
    logic              exc;
  } FetchEntry_t;

  // What ID sees when the queue is empty: PC 0, a NOP, no exception.
  localparam FetchEntry_t EMPTY_ENTRY = '{pc: '0, instr: INST_NOP, exc: 1'b0};

  function automatic FetchEntry_t make_entry(input logic [PC_W-1:0]   pc,
                                             input logic [INST_W-1:0] instr,
                                             input logic              exc);
    FetchEntry_t e;
    e.pc    = pc;
    e.instr = instr;
    e.exc   = exc;
    return e;
  endfunction

endpackage

// File: rtl/if_id_inst_queue_if.sv
// IF push side, ID pop side and flush of the fetch queue; master drives IF/ID requests,
// slave is the queue itself.
interface if_id_inst_queue_if
  import if_id_inst_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              if_valid;
  logic              if_ready;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_instr;
  logic              if_exc;
  logic              id_valid;
  logic              id_ready;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_instr;
  logic              id_exc;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, if_valid, if_pc, if_instr, if_exc, id_ready,
    input  if_ready, id_valid, id_pc, id_instr, id_exc, count
  );

  modport slave (
    input  flush, if_valid, if_pc, if_instr, if_exc, id_ready,
    output if_ready, id_valid, id_pc, id_instr, id_exc, count
  );

endinterface

// File: rtl/if_id_inst_queue.sv
// In-order IF->ID instruction queue, first-word fall-through, one cycle push-to-head latency.
// if_ready depends only on occupancy (no ID->IF comb path); flush empties it in one cycle.
module if_id_inst_queue
  import if_id_inst_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  if_id_inst_queue_if.slave   q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  FetchEntry_t        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               full;
  logic               push;
  logic               pop;
  FetchEntry_t        head;

  assign full       = (cnt == CNT_W'(DEPTH));
  assign q.if_ready = !rst && !full;
  assign q.id_valid = !rst && (cnt != '0);

  assign push = q.if_valid && q.if_ready;
  assign pop  = q.id_valid && q.id_ready;

  always_comb begin
    cnt_next = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + CNT_W'(1);
      2'b01:   cnt_next = cnt - CNT_W'(1);
      default: cnt_next = cnt;
    endcase
  end

  // Storage is written only on an accepted push, so idle X on if_* never lands in the array.
  always_ff @(posedge clk) begin
    if (push && !q.flush) begin
      mem[wr_ptr] <= make_entry(q.if_pc, q.if_instr, q.if_exc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt_next;
    end
  end

  // Empty head is forced to a NOP so stale or uninitialised storage never reaches ID.
  always_comb begin
    head = EMPTY_ENTRY;
    if (q.id_valid) head = mem[rd_ptr];
  end

  assign q.id_pc    = head.pc;
  assign q.id_instr = head.instr;
  assign q.id_exc   = head.exc;
  assign q.count    = cnt;

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    cnt <= CNT_W'(DEPTH));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    full |-> !push);

  a_head_stable_on_stall: assert property (@(posedge clk) disable iff (rst)
    (q.id_valid && !q.id_ready && !q.flush) |=>
      ($stable(q.id_pc) && $stable(q.id_instr) && $stable(q.id_exc)));

endmodule
